// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: opcode field layout, special
// instruction constants and the fetch-state encoding.
package fetch_unit_pkg;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int OPCODE_W   = 6;

  localparam logic [OPCODE_W-1:0] HALT_OPCODE = 6'b111111;
  localparam logic [31:0]         NOP         = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } fetch_state_t;

  function automatic logic is_opcode(input logic [31:0] instr,
                                     input logic [OPCODE_W-1:0] op);
    return instr[OPCODE_MSB:OPCODE_LSB] == op;
  endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register: load beats increment, otherwise hold.
module pc_reg #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_pc,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  // Increment wraps naturally at 2^ADDR_W; there is no carry out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pc <= '0;
    else if (load)
      pc <= load_pc;
    else if (inc)
      pc <= pc + ADDR_W'(1);
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, captures the combinational memory word
// into the IF/ID register, and handles stall, redirect, halt and range faults.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                  ADDR_W      = 16,
  parameter int                  INSTR_W     = 32,
  parameter int                  MEM_DEPTH   = 15,
  parameter int                  BOOT_CYCLES = 1,
  parameter logic [OPCODE_W-1:0] HALT_OPCODE = fetch_unit_pkg::HALT_OPCODE
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc,
  output logic               id_valid,
  output logic               halted,
  output logic               fault
);

  localparam int BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES + 1) : 1;
  localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYCLES - 1);
  // One extra bit so a depth of 2^ADDR_W is representable.
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W + 1)'(MEM_DEPTH);

  fetch_state_t      state, state_next;
  logic [BOOT_W-1:0] boot_cnt;
  logic [ADDR_W-1:0] pc;
  logic              pc_load, pc_inc;
  logic              capture, squash, drop_valid;
  logic              set_fault, set_halt, clr_halt;
  logic              out_of_range, halt_word;

  assign imem_addr    = pc;
  assign out_of_range = {1'b0, pc} >= DEPTH;
  assign halt_word    = is_opcode(imem_data, HALT_OPCODE);

  pc_reg #(.ADDR_W(ADDR_W)) u_pc (
    .clk     (clk),
    .rst     (rst),
    .load    (pc_load),
    .load_pc (redirect_pc),
    .inc     (pc_inc),
    .pc      (pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= BOOT;
    else
      state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      boot_cnt <= '0;
    else if (state == BOOT)
      boot_cnt <= boot_cnt + BOOT_W'(1);
  end

  always_comb begin
    state_next = state;
    pc_load    = 1'b0;
    pc_inc     = 1'b0;
    capture    = 1'b0;
    squash     = 1'b0;
    drop_valid = 1'b0;
    set_fault  = 1'b0;
    set_halt   = 1'b0;
    clr_halt   = 1'b0;
    case (state)
      BOOT: begin
        if (boot_cnt == BOOT_LAST)
          state_next = RUN;
      end
      RUN: begin
        if (redirect) begin
          pc_load = 1'b1;
          squash  = 1'b1;
        end else if (stall) begin
          state_next = RUN;
        end else if (out_of_range) begin
          state_next = HALT;
          set_fault  = 1'b1;
          set_halt   = 1'b1;
          drop_valid = 1'b1;
        end else begin
          capture = 1'b1;
          pc_inc  = 1'b1;
          if (halt_word) begin
            state_next = HALT;
            set_halt   = 1'b1;
          end
        end
      end
      HALT: begin
        // A halt reached down a mispredicted path can still be redirected away;
        // a fault cannot.
        if (redirect && !fault) begin
          state_next = RUN;
          clr_halt   = 1'b1;
          pc_load    = 1'b1;
          drop_valid = 1'b1;
        end else if (id_valid && !stall) begin
          drop_valid = 1'b1;
        end
      end
      default: state_next = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_instr <= '0;
      id_pc    <= '0;
      id_valid <= 1'b0;
    end else if (capture) begin
      id_instr <= imem_data;
      id_pc    <= pc;
      id_valid <= 1'b1;
    end else if (squash) begin
      id_instr <= INSTR_W'(NOP);
      id_valid <= 1'b0;
    end else if (drop_valid) begin
      id_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halted <= 1'b0;
      fault  <= 1'b0;
    end else begin
      if (set_fault)
        fault <= 1'b1;
      if (set_halt)
        halted <= 1'b1;
      else if (clr_halt)
        halted <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a behavioural fetch model predicts the
// outputs after every edge, and a monitor compares them with the DUT.
module tb_fetch_unit;

  localparam int DEPTH = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] imem_addr;
  logic [31:0] imem_data;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic [31:0] id_instr;
  logic [15:0] id_pc;
  logic        id_valid, halted, fault;

  logic        w_rst = 1'b1;
  logic        w_stall = 1'b0;
  logic        w_redirect = 1'b0;
  logic [15:0] w_redirect_pc = '0;
  logic [15:0] w_addr, w_pc;
  logic [31:0] w_data, w_instr;
  logic        w_valid, w_halted, w_fault;

  logic [31:0] mem [0:65535];

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] instr;
    logic [15:0] pc;
    logic        valid;
    logic        halted;
    logic        fault;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: 0 = booting, 1 = running, 2 = stopped.
  int          m_mode, m_boot, m_pc, m_idpc;
  logic [31:0] m_instr;
  bit          m_valid, m_halted, m_fault;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr];
  assign w_data    = mem[w_addr];

  fetch_unit dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .id_instr(id_instr), .id_pc(id_pc), .id_valid(id_valid),
    .halted(halted), .fault(fault)
  );

  fetch_unit #(.MEM_DEPTH(65536)) u_wrap (
    .clk(clk), .rst(w_rst), .imem_addr(w_addr), .imem_data(w_data),
    .stall(w_stall), .redirect(w_redirect), .redirect_pc(w_redirect_pc),
    .id_instr(w_instr), .id_pc(w_pc), .id_valid(w_valid),
    .halted(w_halted), .fault(w_fault)
  );

  task automatic check_val(input string name, input logic [31:0] got,
                           input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fails++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, got, want);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    n_checks++;
    if (imem_addr !== e.addr || id_instr !== e.instr || id_pc !== e.pc ||
        id_valid !== e.valid || halted !== e.halted || fault !== e.fault) begin
      n_fails++;
      $display("[TB] FAIL fetch_outputs at %0t: got addr=%h instr=%h pc=%h v=%b h=%b f=%b, expected addr=%h instr=%h pc=%h v=%b h=%b f=%b",
               $time, imem_addr, id_instr, id_pc, id_valid, halted, fault,
               e.addr, e.instr, e.pc, e.valid, e.halted, e.fault);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_boot = 0; m_pc = 0; m_idpc = 0;
    m_instr = 32'h0; m_valid = 0; m_halted = 0; m_fault = 0;
  endtask

  task automatic model_step(input bit st, input bit rd, input int rpc);
    logic [31:0] w;
    case (m_mode)
      0: begin
        m_boot++;
        if (m_boot == 1) m_mode = 1;
      end
      1: begin
        if (rd) begin
          m_pc = rpc; m_valid = 0; m_instr = 32'h0;
        end else if (st) begin
          m_mode = 1;
        end else if (m_pc >= DEPTH) begin
          m_mode = 2; m_fault = 1; m_halted = 1; m_valid = 0;
        end else begin
          w = mem[m_pc];
          m_instr = w; m_idpc = m_pc; m_valid = 1;
          m_pc = (m_pc + 1) % 65536;
          if (w[31:26] == 6'b111111) begin
            m_mode = 2; m_halted = 1;
          end
        end
      end
      default: begin
        if (rd && !m_fault) begin
          m_mode = 1; m_halted = 0; m_pc = rpc; m_valid = 0;
        end else if (m_valid && !st) begin
          m_valid = 0;
        end
      end
    endcase
  endtask

  // Drive one cycle of inputs and queue what the model says follows the edge.
  task automatic applyStimulus(input bit st, input bit rd, input int rpc);
    exp_t e;
    @(negedge clk);
    stall = st;
    redirect = rd;
    redirect_pc = rpc[15:0];
    model_step(st, rd, rpc);
    e.addr = m_pc[15:0]; e.instr = m_instr; e.pc = m_idpc[15:0];
    e.valid = m_valid; e.halted = m_halted; e.fault = m_fault;
    exp_q.push_back(e);
  endtask

  // Mid-cycle asynchronous reset; outputs must clear before any clock edge.
  task automatic do_reset();
    @(posedge clk);
    #3;
    stall = 0; redirect = 0; redirect_pc = '0;
    rst = 1'b1;
    #1;
    check_val("reset_imem_addr", {16'h0, imem_addr}, 32'h0);
    check_val("reset_id_instr", id_instr, 32'h0);
    check_val("reset_id_pc", {16'h0, id_pc}, 32'h0);
    check_val("reset_flags", {29'h0, id_valid, halted, fault}, 32'h0);
    model_reset();
    exp_q.delete();
    rst = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    logic [31:0] w;
    for (int i = 0; i < 65536; i++) begin
      w = $urandom;
      if (w[31:26] == 6'b111111) w[31] = 1'b0;
      mem[i] = w;
    end
    mem[0]  = 32'h0000_0000;
    mem[1]  = 32'h5801_0000;
    mem[2]  = 32'h0420_1000;
    mem[3]  = 32'h0803_0001;
    mem[6]  = 32'hFC00_0000;
    mem[11] = 32'hFC00_1234;

    do_reset();

    // Boot edge, then words 0..2.
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0);
    // Stall while id_pc = 2.
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    // Redirect to 9 with a simultaneous stall at pc = 5.
    applyStimulus(1, 1, 9);
    applyStimulus(0, 0, 0);
    // Halt word at 6, drain, then recover to 2.
    applyStimulus(0, 1, 6);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 1, 2);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    // Last valid word, then fault; redirect is then ignored.
    applyStimulus(0, 1, 14);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 1, 3);
    applyStimulus(0, 0, 0);
    do_reset();

    for (int i = 0; i < 600; i++) begin
      if (m_fault && $urandom_range(0, 3) == 0)
        do_reset();
      else
        applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                      int'($urandom_range(0, 16)));
    end

    // Wrap-around on a full-depth instance.
    @(posedge clk);
    #3 w_rst = 1'b0;
    @(negedge clk);
    stall = 0; redirect = 0;
    @(negedge clk);
    w_redirect = 1'b1;
    w_redirect_pc = 16'hFFFE;
    @(negedge clk);
    w_redirect = 1'b0;
    @(posedge clk);
    #2;
    check_val("wrap_addr_ffff", {16'h0, w_addr}, 32'h0000_FFFF);
    check_val("wrap_pc_fffe", {16'h0, w_pc}, 32'h0000_FFFE);
    @(posedge clk);
    #2;
    check_val("wrap_addr_0000", {16'h0, w_addr}, 32'h0);
    check_val("wrap_pc_ffff", {16'h0, w_pc}, 32'h0000_FFFF);
    check_val("wrap_instr_ffff", w_instr, mem[65535]);
    check_val("wrap_valid", {31'h0, w_valid}, 32'h1);
    @(posedge clk);
    #2;
    check_val("wrap_addr_0001", {16'h0, w_addr}, 32'h1);
    check_val("wrap_pc_0000", {16'h0, w_pc}, 32'h0);
    check_val("wrap_no_fault", {30'h0, w_halted, w_fault}, 32'h0);

    check_val("scoreboard_drained", exp_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage for the core.
- Owns the program counter and drives the word address into the instruction memory.
- Captures the 32-bit word the memory returns combinationally in the same cycle, and presents it with its PC to decode through an IF/ID register.
- Handles stall, branch redirect, the post-reset memory-load cycle, halt detection and out-of-range fetch faults.

Parameters:
- ADDR_W, 16, PC / instruction-memory address width (word-addressed).
- INSTR_W, 32, instruction width.
- MEM_DEPTH, 15, number of valid instruction words; fetching at or beyond this address is a fault.
- BOOT_CYCLES, 1, cycles after reset before the first fetch (memory loads its contents on its first clock edge).
- HALT_OPCODE, 6'b111111, value of instr[31:26] that halts fetch.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_addr  out  ADDR_W  word address to instruction memory; equals the PC register.
- imem_data  in  INSTR_W  instruction word read combinationally at imem_addr.
- stall  in  1  decode/hazard stall; hold PC and the IF/ID register.
- redirect  in  1  taken branch/jump from a later stage.
- redirect_pc  in  ADDR_W  target address, valid when redirect=1.
- id_instr  out  INSTR_W  IF/ID instruction register.
- id_pc  out  ADDR_W  address the id_instr word was fetched from.
- id_valid  out  1  id_instr holds a real instruction (0 = bubble).
- halted  out  1  fetch stopped on a halt opcode or a fault.
- fault  out  1  fetch attempted at pc >= MEM_DEPTH (sticky until reset).

Behaviour:
- Reset (async, any time, including mid-redirect or in HALT):
  - pc=0, state=BOOT, boot counter=0.
  - id_instr=0, id_pc=0, id_valid=0, halted=0, fault=0.
- States: BOOT, RUN, HALT.
- BOOT:
  - pc held at 0; IF/ID held as bubble; stall and redirect ignored.
  - After BOOT_CYCLES rising edges, go to RUN.
  - First capture therefore occurs on edge BOOT_CYCLES+1.
- RUN, one priority-ordered action per edge:
  1. redirect=1: pc<=redirect_pc; id_valid<=0; id_instr<=0 (NOP). Wins over stall and halt. The word currently at imem_addr is discarded.
  2. stall=1: pc, id_instr, id_pc, id_valid all unchanged.
  3. pc >= MEM_DEPTH: state<=HALT; fault<=1; halted<=1; id_valid<=0; pc unchanged.
  4. Otherwise:
     - id_instr<=imem_data; id_pc<=pc; id_valid<=1.
     - pc<=pc+1, modulo 2^ADDR_W (0xFFFF wraps to 0x0000).
     - If imem_data[31:26]==HALT_OPCODE, also state<=HALT and halted<=1. The halt word itself is delivered with id_valid=1, and pc still advances by 1.
- HALT:
  - If id_valid=1 and stall=0, id_valid<=0 on the next edge. This drains the last word exactly once.
  - pc frozen.
  - redirect=1 and fault=0: state<=RUN; halted<=0; pc<=redirect_pc; id_valid<=0. This recovers from a halt fetched on a wrong path.
  - fault=1: redirect ignored; only reset exits.
- Latency:
  - Word at address A appears on id_instr one edge after imem_addr=A with no stall or redirect.
  - Redirect costs exactly one bubble.
- Simultaneous events:
  - redirect+stall: redirect wins.
  - redirect with a halt word on imem_data: no halt, word squashed.
  - redirect_pc >= MEM_DEPTH: accepted; the fault is raised on the next RUN cycle.
- Arithmetic: pc increment is unsigned ADDR_W bits; no carry out.

Decomposition:
- Shared core package holds:
  - opcode field position (31:26) and width 6;
  - HALT_OPCODE and NOP (32'h0) constants;
  - fetch-state enum {BOOT, RUN, HALT}.
- One sub-module, pc_reg: PC register with async reset, load (redirect), hold (stall/halt) and increment.
- FSM, boot counter and IF/ID register remain in fetch_unit.

Test Plan:
- Boot and sequential fetch: reset then release; memory words 0..3 = 0x0, 0x58010000, 0x04201000, 0x08030001.
  - imem_addr stays 0 for 1 edge; id_valid rises on edge 2.
  - Then id_pc 0,1,2,3 with matching id_instr, one per edge.
- Stall: assert stall 3 cycles while id_pc=2.
  - id_pc/id_instr/imem_addr frozen at 2 / 0x04201000 / 3.
  - Resumes with id_pc=3 on the first edge after release.
- Redirect: redirect=1, redirect_pc=9 while pc=5, with stall=1 in the same cycle.
  - Next edge: imem_addr=9, id_valid=0, id_instr=0.
  - Following edge: id_pc=9, id_valid=1.
- Halt: word at address 6 = 0xFC000000.
  - id_pc=6, id_valid=1 for one cycle; then halted=1, id_valid=0, imem_addr frozen at 7.
  - redirect_pc=2 then resumes at 2 with halted=0.
- Fault and wrap: redirect_pc=14 → word 14 captured, then fault=1, halted=1, imem_addr=15.
  - A later redirect is ignored.
  - Separately, with MEM_DEPTH=65536 and pc=0xFFFF, the next pc is 0x0000.
- Async reset in HALT with fault=1, asserted mid-cycle: all outputs return to their reset values immediately, without waiting for a clock edge.
